// File: rtl/conv_pkg.sv
// Shared types and constants for the fp16 convolution channel accumulator.
// Contents: fp16_t payload type, accumulator FSM state enum, fp16 constants.
package conv_pkg;

  localparam int unsigned FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;
  // Canonical quiet NaN returned for any invalid addition
  localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/conv_accum_fp16_fadd.sv
// Combinational IEEE-754 binary16 adder, round-to-nearest-even, full subnormal
// support. Any NaN operand or Inf + (-Inf) yields the canonical quiet NaN.
// Ports:
//   num1  in   16  first operand
//   num2  in   16  second operand
//   sum_c out  16  num1 + num2 (combinational)
module conv_accum_fp16_fadd
  import conv_pkg::*;
(
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [15:0] sum_c
);

  // 11-bit significand plus guard, round and sticky bits
  localparam int unsigned EXT_W = 14;
  // Wide enough that no bit falls off for the largest exponent gap (29)
  localparam int unsigned ALN_W = 45;

  logic             a_nan, b_nan, a_inf, b_inf;
  fp16_t            big_op, small_op;
  logic [4:0]       l_exp, s_exp, exp_diff, exp_fin;
  logic [10:0]      l_sig, s_sig, sig_fin;
  logic [ALN_W-1:0] aligned;
  logic [EXT_W-1:0] l_ext, s_ext, norm;
  logic [EXT_W:0]   raw;
  logic [3:0]       lz;
  logic [6:0]       exp_w, shamt;
  logic             rnd_up;
  logic [11:0]      sig_rnd;

  always_comb begin
    a_nan    = (&num1[14:10]) && (|num1[9:0]);
    b_nan    = (&num2[14:10]) && (|num2[9:0]);
    a_inf    = (&num1[14:10]) && !(|num1[9:0]);
    b_inf    = (&num2[14:10]) && !(|num2[9:0]);
    big_op   = num1;
    small_op = num2;
    lz       = 4'd0;
    shamt    = 7'd0;
    norm     = '0;
    sig_fin  = '0;
    sum_c    = FP16_ZERO;

    // Order by magnitude so the aligned subtraction never goes negative
    if (num1[14:0] < num2[14:0]) begin
      big_op   = num2;
      small_op = num1;
    end

    // Subnormals share the exponent of the smallest normal
    l_exp    = (big_op[14:10] == 5'd0) ? 5'd1 : big_op[14:10];
    s_exp    = (small_op[14:10] == 5'd0) ? 5'd1 : small_op[14:10];
    l_sig    = {|big_op[14:10], big_op[9:0]};
    s_sig    = {|small_op[14:10], small_op[9:0]};
    exp_diff = l_exp - s_exp;

    aligned  = {s_sig, 34'd0} >> exp_diff;
    s_ext    = {aligned[44:32], |aligned[31:0]};
    l_ext    = {l_sig, 3'b000};

    raw      = (big_op[15] ^ small_op[15]) ? ({1'b0, l_ext} - {1'b0, s_ext})
                                           : ({1'b0, l_ext} + {1'b0, s_ext});
    exp_w    = 7'(l_exp);

    if (raw[EXT_W]) begin
      // Carry out: shift right once, folding the lost bit into sticky
      norm  = {raw[14:2], raw[1] | raw[0]};
      exp_w = exp_w + 7'd1;
    end else begin
      for (int i = 0; i < int'(EXT_W); i++) begin
        if (raw[i]) lz = 4'(int'(EXT_W) - 1 - i);
      end
      // Never normalise below the minimum exponent: result becomes subnormal
      shamt = (7'(lz) < (exp_w - 7'd1)) ? 7'(lz) : (exp_w - 7'd1);
      norm  = raw[EXT_W-1:0] << shamt;
      exp_w = exp_w - shamt;
    end

    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    sig_rnd = {1'b0, norm[13:3]} + 12'(rnd_up);
    if (sig_rnd[11]) begin
      sig_fin = sig_rnd[11:1];
      exp_w   = exp_w + 7'd1;
    end else begin
      sig_fin = sig_rnd[10:0];
    end
    // Hidden bit clear means subnormal (also covers subnormal rounding up to normal)
    exp_fin = sig_fin[10] ? exp_w[4:0] : 5'd0;

    if (a_nan || b_nan || (a_inf && b_inf && (num1[15] != num2[15]))) begin
      sum_c = FP16_QNAN;
    end else if (a_inf) begin
      sum_c = num1;
    end else if (b_inf) begin
      sum_c = num2;
    end else if (raw == '0) begin
      // Exact cancellation gives +0; only -0 + -0 keeps the sign
      sum_c = {num1[15] & num2[15], 15'd0};
    end else if (exp_w >= 7'd31) begin
      sum_c = {big_op[15], 5'h1F, 10'd0};
    end else begin
      sum_c = {big_op[15], exp_fin, sig_fin[9:0]};
    end
  end

endmodule

// File: rtl/conv_accum_fp16.sv
// Channel accumulator: sums NUM_CH fp16 partial sums plus a bias into one fp16
// pixel, presents it on a valid/ready port and stalls upstream while held.
// Optional macro CONV_ACC_RELU_EN: clamp results with the sign bit set to +0
// on the output path (accumulator itself is left untouched).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clr                   abort current group / drop held result
//   bias [15:0]           bias, used on the first beat of a group
//   in_valid, in_ready    input handshake
//   in_data [15:0]        fp16 partial sum
//   out_valid, out_ready  output handshake
//   out_data [15:0]       accumulated pixel
//   busy                  group in progress or result held
module conv_accum_fp16
  import conv_pkg::*;
#(
  parameter int unsigned NUM_CH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  localparam int unsigned     CNT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CH - 1);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fp16_t            acc_q, acc_d;
  fp16_t            add_a, add_sum;
  fp16_t            out_data_d;
  logic             in_ready_d, out_valid_d, busy_d;
  logic             beat;

  // First beat of a group starts from the bias instead of the running sum
  assign add_a = (cnt_q == '0) ? bias : acc_q;

  conv_accum_fp16_fadd u_fadd (
    .num1  (add_a),
    .num2  (in_data),
    .sum_c (add_sum)
  );

  // Next-state, counter, accumulator and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    beat    = in_valid && in_ready && !clr;

    if (clr) begin
      cnt_d   = '0;
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (beat) begin
            acc_d = add_sum;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_ACCUM;
        end
        default: state_d = ST_ACCUM;
      endcase
    end

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (cnt_d != '0) || (state_d == ST_HOLD);
`ifdef CONV_ACC_RELU_EN
    out_data_d  = acc_d[15] ? FP16_ZERO : acc_d;
`else
    out_data_d  = acc_d;
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= '0;
      acc_q     <= FP16_ZERO;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= FP16_ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      out_data  <= out_data_d;
    end
  end

endmodule
